dp_mem_responder: RTL and testbench
===================================

DP_MEM_RESPONDER -- requirements
Module: dp_mem_responder

Interface
REQ-001 SHALL have parameter MAT_BEATS, default 8: number of 32-bit words per matrix burst.
REQ-002 SHALL have parameter ADDR_W, default 32: address width in bits.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have the imem ports imemREN (in, 1), imemaddr (in, ADDR_W), ihit (out, 1) and imemload (out, 32).
REQ-006 SHALL have the dmem ports dmemREN (in, 1), dmemWEN (in, 1), dmemaddr (in, ADDR_W), dmemstore (in, 32), dhit (out, 1) and dmemload (out, 32).
REQ-007 SHALL have the matrix ports mmemREN (in, 1), mmemaddr (in, ADDR_W), mvalid (out, 1, one beat valid), mhit (out, 1, burst complete) and mmemload (out, 32).
REQ-008 SHALL have the halt port halt (in, 1): the datapath has halted.
REQ-009 SHALL have the RAM ports ramREN (out, 1), ramWEN (out, 1), ramaddr (out, ADDR_W), ramstore (out, 32), ramload (in, 32) and ram_ready (in, 1, access complete this cycle).

Function
REQ-010 SHALL implement the FSM states IDLE, DSERV, MSERV, ISERV and HALTED, with the state held in a register.
REQ-011 SHALL, in IDLE, grant the first asserted request in priority order: dmem (REN or WEN), then mmem, then imem. The request is sampled at the clock edge, and the next state is the matching SERV state.
REQ-012 SHALL raise an anti-starvation flag when an MSERV burst completes. While the flag is set and imemREN is high, imem outranks mmem at the next grant, and that grant clears the flag.
REQ-013 SHALL, in DSERV, drive ramaddr=dmemaddr and ramstore=dmemstore. dmemWEN has priority over dmemREN, and ramWEN/ramREN are asserted exclusively.
REQ-014 SHALL assert dhit (and likewise ihit) combinationally as (state==SERV) && ram_ready, pass dmemload/imemload straight from ramload, and return to IDLE on the next edge.
REQ-015 SHALL latch the mmemaddr base at grant, clear the beat counter, and drive ramaddr = base + 4*beat, computed modulo 2^ADDR_W.
REQ-016 SHALL, in MSERV, assert mvalid for exactly one cycle per ram_ready and advance beat. mhit is asserted together with the final mvalid (beat==MAT_BEATS-1), and the FSM then returns to IDLE.
REQ-017 SHALL hold all ram* strobes low in IDLE and HALTED. Minimum request-to-hit latency is 1 cycle after the grant edge; there is no upper bound, since the FSM waits on ram_ready.
REQ-018 SHALL, when halt rises during a SERV state, complete that transaction (a full burst for MSERV) and then enter HALTED; from IDLE, halt goes directly to HALTED.
REQ-019 SHALL, in HALTED, ignore all requests and never assert any hit output. HALTED is left only by reset.
REQ-020 SHALL require the datapath to hold a request stable until its hit. A request dropped mid-service is treated as still active and completes normally.

Reset
REQ-021 SHALL, on reset, set the state to IDLE, beat to 0, base to 0 and the starvation flag to 0.
REQ-022 SHALL hold ihit, dhit, mvalid, mhit, ramREN and ramWEN at 0, and imemload, dmemload, mmemload, ramaddr and ramstore at 0, during reset.
REQ-023 SHALL, when reset is asserted mid-burst, abandon the burst immediately with no partial mhit, and return to IDLE after release.

Configuration
REQ-024 SHALL support macro DP_MEM_PERF_EN. When defined, it adds 32-bit saturating outputs: perf_istall (cycles with imemREN high and ihit low) and perf_bursts (completed matrix bursts). Both reset to 0.
REQ-025 SHALL, without DP_MEM_PERF_EN, contain no perf ports or logic, and its function is otherwise identical.

Structure
REQ-026 SHALL place the dp_mem_state_t enum, the MAT_BEATS default and the word_t/addr_t typedefs in datapath_pkg.
REQ-027 SHALL implement the perf counters as sub-module dp_mem_perf, instantiated only under DP_MEM_PERF_EN.

Verification
REQ-028 SHALL verify this case: dmemREN and imemREN both high at 0x100 and 0x0, with ram_ready after 2 cycles. dhit is required first with dmemload=RAM[0x100], and ihit follows.
REQ-029 SHALL verify this case: dmemWEN with dmemREN, at 0x40 with store 0xDEADBEEF. ramWEN=1 and ramREN=0 are required, and a later read of 0x40 returns 0xDEADBEEF.
REQ-030 SHALL verify this case: mmemREN at base 0xFFFFFFF8 with MAT_BEATS=8. Eight mvalid beats are required with addresses wrapping to 0x0..0x14, and mhit only on beat 7.
REQ-031 SHALL verify this case: mmemREN and imemREN held continuously. Grants are required to alternate burst, ifetch, burst.
REQ-032 SHALL verify this case: halt asserted at beat 3 of a burst. The burst is required to finish through mhit, and no ihit occurs afterwards.
REQ-033 SHALL verify this case: nrst low at beat 4. All outputs are required to be 0 immediately, and no mhit occurs; after release, a new mmemREN restarts at beat 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath memory-side types: responder FSM states, word/address types, burst default.
// Pure declarations; no timing or flow control lives here.
package datapath_pkg;

  localparam int MAT_BEATS_DEF = 8;
  localparam int ADDR_W_DEF    = 32;

  typedef logic [31:0]           word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DSERV  = 3'd1,
    MSERV  = 3'd2,
    ISERV  = 3'd3,
    HALTED = 3'd4
  } dp_mem_state_t;

  function automatic logic is_serv(input dp_mem_state_t s);
    return (s == DSERV) || (s == MSERV) || (s == ISERV);
  endfunction

endpackage

// File: rtl/dp_mem_perf.sv
// Saturating stall/burst counters for the memory responder.
// Registered, 1-cycle update; counters hold at all-ones instead of wrapping.
module dp_mem_perf
  import datapath_pkg::*;
(
  input  logic  CLK,
  input  logic  nrst,
  input  logic  imemREN,
  input  logic  ihit,
  input  logic  mhit,
  output word_t perf_istall,
  output word_t perf_bursts
);

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      perf_istall <= '0;
      perf_bursts <= '0;
    end else begin
      if (imemREN && !ihit && (perf_istall != '1))
        perf_istall <= perf_istall + 32'd1;
      if (mhit && (perf_bursts != '1))
        perf_bursts <= perf_bursts + 32'd1;
    end
  end

endmodule

// File: rtl/dp_mem_responder.sv
// Arbitrates dmem/mmem/imem requests onto one RAM port; optional DP_MEM_PERF_EN adds perf counters.
// Latency: grant on the request edge, hit combinational with ram_ready (>=1 cycle); waits on ram_ready indefinitely.
module dp_mem_responder
  import datapath_pkg::*;
#(
  parameter int MAT_BEATS = MAT_BEATS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output word_t             imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  word_t             dmemstore,
  output logic              dhit,
  output word_t             dmemload,
  input  logic              mmemREN,
  input  logic [ADDR_W-1:0] mmemaddr,
  output logic              mvalid,
  output logic              mhit,
  output word_t             mmemload,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  logic              ram_ready
`ifdef DP_MEM_PERF_EN
  ,
  output word_t             perf_istall,
  output word_t             perf_bursts
`endif
);

  localparam int BEAT_W = (MAT_BEATS > 1) ? $clog2(MAT_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAT_BEATS - 1);

  dp_mem_state_t     state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [ADDR_W-1:0] burst_addr;
  logic              starve, starve_nxt;
  logic              halt_pend, halt_pend_nxt;
  logic              d_wr, d_wr_nxt;
  logic              done;

  // Burst addresses wrap naturally at ADDR_W bits.
  assign burst_addr = base + (ADDR_W'(beat) << 2);

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      beat      <= '0;
      base      <= '0;
      starve    <= 1'b0;
      halt_pend <= 1'b0;
      d_wr      <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      base      <= base_nxt;
      starve    <= starve_nxt;
      halt_pend <= halt_pend_nxt;
      d_wr      <= d_wr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    base_nxt      = base;
    starve_nxt    = starve;
    halt_pend_nxt = halt_pend;
    d_wr_nxt      = d_wr;
    done          = 1'b0;
    ihit          = 1'b0;
    dhit          = 1'b0;
    mvalid        = 1'b0;
    mhit          = 1'b0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    imemload      = '0;
    dmemload      = '0;
    mmemload      = '0;

    case (state)
      IDLE: begin
        halt_pend_nxt = 1'b0;
        if (halt) begin
          state_nxt = HALTED;
        end else if (dmemREN || dmemWEN) begin
          state_nxt = DSERV;
          d_wr_nxt  = dmemWEN;
        end else if (imemREN && (starve || !mmemREN)) begin
          state_nxt  = ISERV;
          starve_nxt = 1'b0;
        end else if (mmemREN) begin
          state_nxt = MSERV;
          base_nxt  = mmemaddr;
          beat_nxt  = '0;
        end
      end
      // Access kind is latched at grant so a dropped strobe cannot flip it mid-service.
      DSERV: begin
        ramaddr  = dmemaddr;
        ramstore = dmemstore;
        ramWEN   = d_wr;
        ramREN   = !d_wr;
        dmemload = ramload;
        dhit     = ram_ready;
        done     = ram_ready;
      end
      ISERV: begin
        ramaddr  = imemaddr;
        ramREN   = 1'b1;
        imemload = ramload;
        ihit     = ram_ready;
        done     = ram_ready;
      end
      MSERV: begin
        ramaddr  = burst_addr;
        ramREN   = 1'b1;
        mmemload = ramload;
        mvalid   = ram_ready;
        if (ram_ready) begin
          if (beat == LAST_BEAT) begin
            mhit       = 1'b1;
            done       = 1'b1;
            starve_nxt = 1'b1;
            beat_nxt   = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A halt seen anywhere in a service is remembered until the service ends.
    if (is_serv(state)) begin
      halt_pend_nxt = halt_pend || halt;
      if (done)
        state_nxt = (halt_pend || halt) ? HALTED : IDLE;
    end
  end

`ifdef DP_MEM_PERF_EN
  dp_mem_perf u_perf (
    .CLK         (CLK),
    .nrst        (nrst),
    .imemREN     (imemREN),
    .ihit        (ihit),
    .mhit        (mhit),
    .perf_istall (perf_istall),
    .perf_bursts (perf_bursts)
  );
`endif

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder: RAM responder with programmable ready latency,
// transaction-level reference checked every cycle, plus hand-computed scenario expectations.
module tb_dp_mem_responder;
  import datapath_pkg::*;

  localparam int MB = 8;
  localparam int AW = 32;

  logic          CLK;
  logic          nrst;
  logic          imemREN, dmemREN, dmemWEN, mmemREN, halt;
  logic [AW-1:0] imemaddr, dmemaddr, mmemaddr, ramaddr;
  word_t         dmemstore, imemload, dmemload, mmemload, ramstore, ramload;
  logic          ihit, dhit, mvalid, mhit, ramREN, ramWEN, ram_ready;
`ifdef DP_MEM_PERF_EN
  word_t         perf_istall, perf_bursts;
`endif

  dp_mem_responder #(.MAT_BEATS(MB), .ADDR_W(AW)) dut (
    .CLK(CLK), .nrst(nrst),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .mmemREN(mmemREN), .mmemaddr(mmemaddr), .mvalid(mvalid), .mhit(mhit), .mmemload(mmemload),
    .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
`ifdef DP_MEM_PERF_EN
    , .perf_istall(perf_istall), .perf_bursts(perf_bursts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int rdy_lat = 2;

  typedef struct {
    byte   kind;
    word_t addr;
    word_t data;
    int    cyc;
    logic  wen;
    logic  ren;
    logic  hit;
  } ev_t;

  ev_t   evq[$];
  ev_t   beatq[$];
  word_t mem[word_t];

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  function automatic word_t rd(input word_t a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM: ready after rdy_lat cycles of a held strobe; writes land when ready.
  initial begin
    int cnt;
    cnt = 0;
    ram_ready = 1'b0;
    ramload = '0;
    forever begin
      @(negedge CLK);
      if (ram_ready) cnt = 0;
      ram_ready = 1'b0;
      ramload = '0;
      if (nrst && (ramREN || ramWEN)) begin
        cnt++;
        if (cnt >= rdy_lat) begin
          ram_ready = 1'b1;
          ramload = rd(ramaddr);
          if (ramWEN) mem[ramaddr] = ramstore;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Reference: each hit must carry the word the memory holds at the requested address.
  initial begin
    int    m_beat;
    logic  halted_m;
    word_t expa;
    ev_t   e;
    m_beat = 0;
    halted_m = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (!nrst) begin
        m_beat = 0;
        halted_m = 1'b0;
        chk("rst_strobes", {ihit, dhit, mvalid, mhit, ramREN, ramWEN}, 0);
        chk("rst_data", imemload | dmemload | mmemload | ramaddr | ramstore, 0);
      end else begin
        chk("ram_excl", ramREN & ramWEN, 0);
        if (dhit) begin
          chk("d_addr", ramaddr, dmemaddr);
          if (dmemWEN) begin
            chk("d_wr_strobe", {ramWEN, ramREN}, 2'b10);
            chk("d_wr_store", ramstore, dmemstore);
          end else begin
            chk("d_load", dmemload, rd(dmemaddr));
          end
          e = '{kind: "D", addr: dmemaddr, data: dmemload, cyc: cyc, wen: ramWEN, ren: ramREN, hit: 1'b1};
          evq.push_back(e);
        end
        if (ihit) begin
          chk("i_addr", ramaddr, imemaddr);
          chk("i_load", imemload, rd(imemaddr));
          e = '{kind: "I", addr: imemaddr, data: imemload, cyc: cyc, wen: ramWEN, ren: ramREN, hit: 1'b1};
          evq.push_back(e);
        end
        if (mvalid) begin
          expa = mmemaddr + 32'(m_beat * 4);
          chk("m_addr", ramaddr, expa);
          chk("m_load", mmemload, rd(expa));
          chk("m_hit_last", mhit, (m_beat == MB - 1));
          e = '{kind: "V", addr: ramaddr, data: mmemload, cyc: cyc, wen: ramWEN, ren: ramREN, hit: mhit};
          beatq.push_back(e);
          if (mhit) begin
            e.kind = "M";
            evq.push_back(e);
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end else begin
          chk("m_hit_alone", mhit, 0);
        end
        if (halted_m)
          chk("halted_quiet", {ihit, dhit, mvalid, mhit, ramREN, ramWEN}, 0);
        if (halt && (dhit || ihit || mhit))
          halted_m = 1'b1;
      end
    end
  end

  task automatic wait_ev(input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      @(negedge CLK);
      #2;
      k++;
    end
    chk("ev_timeout", evq.size() >= n, 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beatq.size() < n && k < budget) begin
      @(negedge CLK);
      #2;
      k++;
    end
    chk("beat_timeout", beatq.size() >= n, 1);
  endtask

  task automatic do_reset();
    imemREN = 0; dmemREN = 0; dmemWEN = 0; mmemREN = 0; halt = 0;
    nrst = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    nrst = 1'b1;
    evq.delete();
    beatq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int    c0;
    word_t exp_wrap[8];
    exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                 32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0014};
    imemREN = 0; dmemREN = 0; dmemWEN = 0; mmemREN = 0; halt = 0;
    imemaddr = '0; dmemaddr = '0; mmemaddr = '0; dmemstore = '0;
    nrst = 1'b1;
    #1 nrst = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_hits", {ihit, dhit, mvalid, mhit}, 0);
    chk("reset_strobes", {ramREN, ramWEN}, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_ramstore", ramstore, 0);
    chk("reset_loads", imemload | dmemload | mmemload, 0);
    nrst = 1'b1;

    // dmem outranks imem; ready after 2 cycles
    rdy_lat = 2;
    @(posedge CLK); #1;
    c0 = cyc;
    dmemaddr = 32'h100; imemaddr = 32'h0; dmemREN = 1; imemREN = 1;
    wait_ev(1, 50);
    dmemREN = 0;
    wait_ev(2, 50);
    imemREN = 0;
    if (evq.size() >= 2) begin
      chk("prio_first_kind", evq[0].kind, "D");
      chk("prio_dload", evq[0].data, 32'h5A5A_0100);
      chk("prio_dhit_cycle", evq[0].cyc - c0, 2);
      chk("prio_second_kind", evq[1].kind, "I");
      chk("prio_iload", evq[1].data, 32'h5A5A_0000);
      chk("prio_ihit_cycle", evq[1].cyc - c0, 5);
    end

    // write wins over read, then read back
    do_reset();
    dmemaddr = 32'h40; dmemstore = 32'hDEAD_BEEF; dmemWEN = 1; dmemREN = 1;
    wait_ev(1, 50);
    dmemWEN = 0; dmemREN = 0;
    @(negedge CLK); #2;
    dmemREN = 1;
    wait_ev(2, 50);
    dmemREN = 0;
    if (evq.size() >= 2) begin
      chk("wr_ramwen", evq[0].wen, 1);
      chk("wr_ramren", evq[0].ren, 0);
      chk("wr_readback", evq[1].data, 32'hDEAD_BEEF);
    end

    // burst wrapping past the top of the address space
    do_reset();
    rdy_lat = 1;
    mmemaddr = 32'hFFFF_FFF8; mmemREN = 1;
    wait_ev(1, 100);
    mmemREN = 0;
    chk("wrap_beats", beatq.size(), 8);
    if (beatq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("wrap_addr", beatq[i].addr, exp_wrap[i]);
        chk("wrap_mhit", beatq[i].hit, (i == 7));
      end
    end

    // continuous mmem + imem: burst, ifetch, burst
    do_reset();
    rdy_lat = 1;
    mmemaddr = 32'h1000; imemaddr = 32'h80; mmemREN = 1; imemREN = 1;
    wait_ev(3, 200);
    mmemREN = 0; imemREN = 0;
    repeat (20) @(posedge CLK);
    chk("alt_count", evq.size(), 3);
    if (evq.size() >= 3) begin
      chk("alt_0", evq[0].kind, "M");
      chk("alt_1", evq[1].kind, "I");
      chk("alt_2", evq[2].kind, "M");
    end

    // halt mid-burst: burst finishes, nothing after
    do_reset();
    rdy_lat = 2;
    mmemaddr = 32'h200; imemaddr = 32'h84; mmemREN = 1; imemREN = 1;
    wait_beats(3, 100);
    halt = 1;
    wait_ev(1, 100);
    mmemREN = 0;
    repeat (30) @(posedge CLK);
    #1;
    chk("halt_events", evq.size(), 1);
    if (evq.size() >= 1) chk("halt_kind", evq[0].kind, "M");
    chk("halt_beats", beatq.size(), 8);
    chk("halt_strobes", {ramREN, ramWEN, ihit}, 0);

    // reset at beat 4 abandons the burst; restart from beat 0
    do_reset();
    rdy_lat = 2;
    mmemaddr = 32'h300; mmemREN = 1;
    wait_beats(4, 100);
    @(posedge CLK); #3;
    nrst = 1'b0;
    #1;
    chk("arst_hits", {ihit, dhit, mvalid, mhit, ramREN, ramWEN}, 0);
    chk("arst_data", imemload | dmemload | mmemload | ramaddr | ramstore, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("arst_no_mhit", evq.size(), 0);
    beatq.delete();
    nrst = 1'b1;
    wait_ev(1, 100);
    mmemREN = 0;
    chk("restart_beats", beatq.size(), 8);
    if (beatq.size() >= 1) chk("restart_addr0", beatq[0].addr, 32'h300);

    repeat (5) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
